// File: rtl/alarm_controller_if.sv
// Alarm controller signal bundle: time/alarm settings, tick and buttons in,
// ringing/snooze status and buzzer out.
//   master : alarm source side (clock counters, settings, buttons)
//   slave  : alarm_controller
interface alarm_controller_if;
  logic        tick_1hz;
  logic [4:0]  cur_hr;
  logic [5:0]  cur_min;
  logic [5:0]  cur_sec;
  logic [4:0]  alarm_hr;
  logic [5:0]  alarm_min;
  logic        alarm_en;
  logic        snooze_btn;
  logic        stop_btn;
  logic        ringing;
  logic        snoozing;
  logic        buzzer;
  logic [11:0] snooze_left;
  logic [3:0]  snooze_cnt;

  modport master (
    output tick_1hz, cur_hr, cur_min, cur_sec, alarm_hr, alarm_min,
           alarm_en, snooze_btn, stop_btn,
    input  ringing, snoozing, buzzer, snooze_left, snooze_cnt
  );

  modport slave (
    input  tick_1hz, cur_hr, cur_min, cur_sec, alarm_hr, alarm_min,
           alarm_en, snooze_btn, stop_btn,
    output ringing, snoozing, buzzer, snooze_left, snooze_cnt
  );
endinterface

// File: rtl/alarm_controller.sv
// Alarm sequencer: detects the hh:mm:00 alarm match on the 1 Hz tick and runs
// the IDLE / RINGING / SNOOZE machine with ring timeout and snooze limit.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : alarm_controller_if.slave (time, settings, tick, buttons in;
//           ringing, snoozing, buzzer, snooze_left, snooze_cnt out, all registered)
module alarm_controller #(
  parameter int unsigned SNOOZE_MIN     = 5,
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input  logic                clk,
  input  logic                reset,
  alarm_controller_if.slave   bus
);

  localparam int unsigned SNOOZE_S = SNOOZE_MIN * 60;
  localparam logic [11:0] SNOOZE_LEN = 12'(SNOOZE_S);
  localparam logic [7:0]  RING_LAST  = 8'(RING_TIMEOUT_S - 1);
  localparam logic [3:0]  SNOOZE_MAX = 4'(MAX_SNOOZE);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  ring_cnt_q, ring_cnt_d;
  logic        buzzer_q, buzzer_d;
  logic [11:0] snooze_left_q, snooze_left_d;
  logic [3:0]  snooze_cnt_q, snooze_cnt_d;
  logic        ringing_q, ringing_d;
  logic        snoozing_q, snoozing_d;
  logic        match_c;
  logic        go_idle_c;

  // Alarm match, evaluated only on the tick cycle and only at second zero
  assign match_c = bus.tick_1hz & bus.alarm_en &
                   (bus.cur_hr == bus.alarm_hr) &
                   (bus.cur_min == bus.alarm_min) &
                   (bus.cur_sec == 6'd0);

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      ring_cnt_q    <= 8'd0;
      buzzer_q      <= 1'b0;
      snooze_left_q <= 12'd0;
      snooze_cnt_q  <= 4'd0;
      ringing_q     <= 1'b0;
      snoozing_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ring_cnt_q    <= ring_cnt_d;
      buzzer_q      <= buzzer_d;
      snooze_left_q <= snooze_left_d;
      snooze_cnt_q  <= snooze_cnt_d;
      ringing_q     <= ringing_d;
      snoozing_q    <= snoozing_d;
    end
  end

  // Next-state logic; buttons take priority over the tick in every state
  always_comb begin
    state_d       = state_q;
    ring_cnt_d    = ring_cnt_q;
    buzzer_d      = buzzer_q;
    snooze_left_d = snooze_left_q;
    snooze_cnt_d  = snooze_cnt_q;
    go_idle_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (match_c) begin
          state_d      = RINGING;
          ring_cnt_d   = 8'd0;
          buzzer_d     = 1'b1;
          snooze_cnt_d = 4'd0;
        end
      end
      RINGING: begin
        if (!bus.alarm_en || bus.stop_btn) begin
          go_idle_c = 1'b1;
        end else if (bus.snooze_btn) begin
          // Once the snooze budget is spent a snooze press acts as stop
          if (snooze_cnt_q < SNOOZE_MAX) begin
            state_d       = SNOOZE;
            snooze_cnt_d  = snooze_cnt_q + 4'd1;
            snooze_left_d = SNOOZE_LEN;
            buzzer_d      = 1'b0;
          end else begin
            go_idle_c = 1'b1;
          end
        end else if (bus.tick_1hz) begin
          if (ring_cnt_q == RING_LAST) begin
            go_idle_c = 1'b1;
          end else begin
            ring_cnt_d = ring_cnt_q + 8'd1;
            buzzer_d   = ~buzzer_q;
          end
        end
      end
      SNOOZE: begin
        if (!bus.alarm_en || bus.stop_btn) begin
          go_idle_c = 1'b1;
        end else if (bus.tick_1hz) begin
          if (snooze_left_q == 12'd1) begin
            state_d       = RINGING;
            snooze_left_d = 12'd0;
            ring_cnt_d    = 8'd0;
            buzzer_d      = 1'b1;
          end else begin
            snooze_left_d = snooze_left_q - 12'd1;
          end
        end
      end
      default: go_idle_c = 1'b1;
    endcase

    if (go_idle_c) begin
      state_d       = IDLE;
      ring_cnt_d    = 8'd0;
      buzzer_d      = 1'b0;
      snooze_left_d = 12'd0;
      snooze_cnt_d  = 4'd0;
    end
  end

  // Status flags registered from the next state so they align with it
  assign ringing_d  = (state_d == RINGING);
  assign snoozing_d = (state_d == SNOOZE);

  assign bus.ringing     = ringing_q;
  assign bus.snoozing    = snoozing_q;
  assign bus.buzzer      = buzzer_q;
  assign bus.snooze_left = snooze_left_q;
  assign bus.snooze_cnt  = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller with SNOOZE_MIN=1, RING_TIMEOUT_S=5, MAX_SNOOZE=2.
// Stimulus pushes the expected outputs for the next cycle into a queue; a
// monitor on the falling edge pops and compares against the DUT outputs.
module tb_alarm_controller;

  logic clk;
  logic reset;
  int   cyc_cnt;
  int   n_chk;
  int   n_fail;

  typedef struct {
    int          due;
    string       name;
    logic [18:0] exp;
  } exp_t;

  exp_t exp_q[$];

  alarm_controller_if bus ();

  alarm_controller #(
    .SNOOZE_MIN     (1),
    .RING_TIMEOUT_S (5),
    .MAX_SNOOZE     (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [18:0] pack_out();
    return {bus.ringing, bus.snoozing, bus.buzzer, bus.snooze_left, bus.snooze_cnt};
  endfunction

  task automatic check(input string nm, input logic [18:0] act, input logic [18:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got r/s/b/left/cnt=%b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d",
               nm, cyc_cnt, act[18], act[17], act[16], act[15:4], act[3:0],
               exp[18], exp[17], exp[16], exp[15:4], exp[3:0]);
    end
  endtask

  // Monitor: compare every expectation that falls due on this cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc_cnt) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, pack_out(), e.exp);
    end
  end

  // Drive one cycle of tick/buttons and queue the outputs expected after it
  task automatic cyc(input logic tk, input logic snz, input logic stp, input string nm,
                     input logic er, input logic es, input logic eb,
                     input logic [11:0] el, input logic [3:0] ec);
    exp_t e;
    bus.tick_1hz   = tk;
    bus.snooze_btn = snz;
    bus.stop_btn   = stp;
    e.due  = cyc_cnt + 1;
    e.name = nm;
    e.exp  = {er, es, eb, el, ec};
    exp_q.push_back(e);
    @(negedge clk);
    bus.tick_1hz   = 1'b0;
    bus.snooze_btn = 1'b0;
    bus.stop_btn   = 1'b0;
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    bus.cur_hr  = h;
    bus.cur_min = m;
    bus.cur_sec = s;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc_cnt = 0;
    n_chk   = 0;
    n_fail  = 0;
    reset   = 1'b0;
    bus.tick_1hz   = 1'b0;
    bus.snooze_btn = 1'b0;
    bus.stop_btn   = 1'b0;
    bus.alarm_en   = 1'b1;
    bus.alarm_hr   = 5'd7;
    bus.alarm_min  = 6'd30;
    set_time(5'd7, 6'd29, 6'd59);

    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b0, "reset_state", 0, 0, 0, 12'd0, 4'd0);
    reset = 1'b1;
    @(negedge clk);

    // Normal ring and timeout after exactly five ticks
    cyc(1'b1, 1'b0, 1'b0, "pre_match", 0, 0, 0, 12'd0, 4'd0);
    set_time(5'd7, 6'd30, 6'd0);
    cyc(1'b1, 1'b0, 1'b0, "match", 1, 0, 1, 12'd0, 4'd0);
    set_time(5'd7, 6'd30, 6'd1);
    cyc(1'b0, 1'b0, 1'b0, "ring_hold", 1, 0, 1, 12'd0, 4'd0);
    for (int i = 1; i <= 4; i++)
      cyc(1'b1, 1'b0, 1'b0, "ring_toggle", 1, 0, logic'(~i[0]), 12'd0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, "ring_timeout", 0, 0, 0, 12'd0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, "idle_after_to", 0, 0, 0, 12'd0, 4'd0);

    // Rematch, snooze twice, third snooze acts as stop
    set_time(5'd7, 6'd30, 6'd0);
    cyc(1'b1, 1'b0, 1'b0, "rematch", 1, 0, 1, 12'd0, 4'd0);
    cyc(1'b1, 1'b1, 1'b0, "snooze1_tick", 0, 1, 0, 12'd60, 4'd1);
    cyc(1'b0, 1'b1, 1'b0, "snooze_ignored", 0, 1, 0, 12'd60, 4'd1);
    for (int i = 1; i <= 59; i++)
      cyc(1'b1, 1'b0, 1'b0, "snooze1_down", 0, 1, 0, 12'(60 - i), 4'd1);
    cyc(1'b1, 1'b0, 1'b0, "snooze1_end", 1, 0, 1, 12'd0, 4'd1);
    cyc(1'b1, 1'b0, 1'b0, "ring_after_snz", 1, 0, 0, 12'd0, 4'd1);
    cyc(1'b0, 1'b1, 1'b0, "snooze2", 0, 1, 0, 12'd60, 4'd2);
    for (int i = 1; i <= 59; i++)
      cyc(1'b1, 1'b0, 1'b0, "snooze2_down", 0, 1, 0, 12'(60 - i), 4'd2);
    cyc(1'b1, 1'b0, 1'b0, "snooze2_end", 1, 0, 1, 12'd0, 4'd2);
    cyc(1'b0, 1'b1, 1'b0, "snooze3_stop", 0, 0, 0, 12'd0, 4'd0);

    // Stop and snooze together: stop wins
    cyc(1'b1, 1'b0, 1'b0, "match_b", 1, 0, 1, 12'd0, 4'd0);
    cyc(1'b0, 1'b1, 1'b1, "stop_and_snz", 0, 0, 0, 12'd0, 4'd0);

    // alarm_en dropped during snooze
    cyc(1'b1, 1'b0, 1'b0, "match_c", 1, 0, 1, 12'd0, 4'd0);
    cyc(1'b0, 1'b1, 1'b0, "snooze_c", 0, 1, 0, 12'd60, 4'd1);
    cyc(1'b1, 1'b0, 1'b0, "snooze_c_dn", 0, 1, 0, 12'd59, 4'd1);
    bus.alarm_en = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, "en_drop_snz", 0, 0, 0, 12'd0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, "disarmed_match", 0, 0, 0, 12'd0, 4'd0);
    bus.alarm_en = 1'b1;

    // Asynchronous reset in the middle of a ring
    cyc(1'b1, 1'b0, 1'b0, "match_d", 1, 0, 1, 12'd0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, "ring_d_tick", 1, 0, 0, 12'd0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, "ring_d_tick2", 1, 0, 1, 12'd0, 4'd0);
    #2 reset = 1'b0;
    #1 check("async_reset", pack_out(), 19'd0);
    @(negedge clk);
    check("reset_held", pack_out(), 19'd0);
    reset = 1'b1;

    // Seconds not zero: no trigger
    set_time(5'd7, 6'd30, 6'd5);
    cyc(1'b1, 1'b0, 1'b0, "sec_nonzero", 0, 0, 0, 12'd0, 4'd0);
    set_time(5'd7, 6'd31, 6'd0);
    cyc(1'b1, 1'b0, 1'b0, "min_mismatch", 0, 0, 0, 12'd0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, "idle_tail", 0, 0, 0, 12'd0, 4'd0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
